// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the register file slice of the pipelined CPU.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   rf_state_e              : init sequencer state encoding
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

endpackage : cpu_pkg

// File: rtl/rf_init_seq.sv
// rf_init_seq: reset-time initialisation sequencer for the register file.
// After reset it walks init_ptr over every entry, one per clock, and presents
// an array write for each one. Once the last entry is written it moves to
// READY and raises ready_o, where it stays until the next reset.
// Ports:
//   clk_i         clock
//   rst_i         synchronous active-high reset, restarts the walk from entry 0
//   ready_o       registered, 1 once every entry has been initialised
//   init_we_o     init write strobe for the current cycle
//   init_addr_o   entry being initialised
//   init_data_o   value written (0, or the entry index when INIT_MODE=1)
module rf_init_seq import cpu_pkg::*; #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int INIT_MODE = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              ready_o,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] init_addr_o,
  output logic [DATA_W-1:0] init_data_o
);

  localparam int DEPTH = 1 << ADDR_W;
  // Pointer is one bit wider than the address so the last entry is compared
  // exactly, and the pointer may step past it without wrapping back to 0.
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

  rf_state_e         state_q;
  logic [ADDR_W:0]   ptr_q;
  logic              ready_q;

  // Init FSM: step the pointer each INIT cycle, go READY after the last entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          ptr_q <= ptr_q + PTR_ONE;
          if (ptr_q == LAST_PTR) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end else begin
            state_q <= ST_INIT;
            ready_q <= 1'b0;
          end
        end
        ST_READY: begin
          state_q <= ST_READY;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Init write port; the index value is truncated or zero-extended to DATA_W.
  always_comb begin
    init_we_o   = (state_q == ST_INIT) && !rst_i;
    init_addr_o = ptr_q[ADDR_W-1:0];
    if (INIT_MODE == 1) begin
      init_data_o = DATA_W'(ptr_q[ADDR_W-1:0]);
    end else begin
      init_data_o = '0;
    end
  end

  assign ready_o = ready_q;

endmodule : rf_init_seq

// File: rtl/reg_file_sync.sv
// reg_file_sync: parametrised synchronous register file, 2 registered read
// ports, 1 write port, optional write-to-read bypass, reset-time init.
// Sits between decode (read ports) and writeback (write port).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   read_addr1/2, read_enable1  read addresses; enable updates both outputs
//   write_addr/data/enable1     user write port (ignored until ready)
//   read_data1/2                registered read data, 1-cycle latency
//   ready                       1 once init has filled every entry
//   write_dropped               1-cycle pulse for a write attempted before ready
module reg_file_sync import cpu_pkg::*; #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int INIT_MODE = 1,
  parameter int BYPASS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  input  logic              read_enable1,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enable1,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              ready,
  output logic              write_dropped
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ready_s;
  logic              init_we_s;
  logic [ADDR_W-1:0] init_addr_s;
  logic [DATA_W-1:0] init_data_s;

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  logic [DATA_W-1:0] rd1_d, rd1_q;
  logic [DATA_W-1:0] rd2_d, rd2_q;
  logic              wd_d, wd_q;
  logic              user_we_s;

  rf_init_seq #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_MODE (INIT_MODE)
  ) u_init_seq (
    .clk_i       (clk),
    .rst_i       (rst),
    .ready_o     (ready_s),
    .init_we_o   (init_we_s),
    .init_addr_o (init_addr_s),
    .init_data_o (init_data_s)
  );

  // Single array write port: init sequencer owns it until ready.
  always_comb begin
    user_we_s   = ready_s && write_enable1;
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    if (init_we_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = init_addr_s;
      mem_wdata_s = init_data_s;
    end else if (user_we_s && !rst) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = write_addr;
      mem_wdata_s = write_data;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Storage array; contents are only meaningful once init has completed.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Read capture with per-port write-first bypass; outputs hold otherwise.
  always_comb begin
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    wd_d  = write_enable1 && !ready_s;
    if (ready_s && read_enable1) begin
      if ((BYPASS == 1) && user_we_s && (write_addr == read_addr1)) begin
        rd1_d = write_data;
      end else begin
        rd1_d = mem_q[read_addr1];
      end
      if ((BYPASS == 1) && user_we_s && (write_addr == read_addr2)) begin
        rd2_d = write_data;
      end else begin
        rd2_d = mem_q[read_addr2];
      end
    end else begin
      rd1_d = rd1_q;
      rd2_d = rd2_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_q <= '0;
      rd2_q <= '0;
      wd_q  <= 1'b0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      wd_q  <= wd_d;
    end
  end

  assign read_data1    = rd1_q;
  assign read_data2    = rd2_q;
  assign ready         = ready_s;
  assign write_dropped = wd_q;

endmodule : reg_file_sync

// File: tb/tb_reg_file_sync.sv
module tb_reg_file_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: 16 x 32, INIT_MODE=1, BYPASS=1
  logic        rst, re, we, rdy, wdrop;
  logic [3:0]  ra1, ra2, wa;
  logic [31:0] wdat, rd1, rd2;

  reg_file_sync #(.DATA_W(32), .ADDR_W(4), .INIT_MODE(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .read_addr1(ra1), .read_addr2(ra2), .read_enable1(re),
    .write_addr(wa), .write_data(wdat), .write_enable1(we),
    .read_data1(rd1), .read_data2(rd2), .ready(rdy), .write_dropped(wdrop));

  // Instance B: 32 x 8, INIT_MODE=1, BYPASS=0 (read-first)
  logic        rst_b, re_b, we_b, rdy_b, wdrop_b;
  logic [4:0]  ra1_b, ra2_b, wa_b;
  logic [7:0]  wdat_b, rd1_b, rd2_b;

  reg_file_sync #(.DATA_W(8), .ADDR_W(5), .INIT_MODE(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst_b), .read_addr1(ra1_b), .read_addr2(ra2_b), .read_enable1(re_b),
    .write_addr(wa_b), .write_data(wdat_b), .write_enable1(we_b),
    .read_data1(rd1_b), .read_data2(rd2_b), .ready(rdy_b), .write_dropped(wdrop_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one cycle; inputs change and outputs are sampled at the negedge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int cnt;

  initial begin
    rst = 1'b1; re = 1'b0; we = 1'b0; ra1 = 4'd0; ra2 = 4'd0; wa = 4'd0; wdat = 32'd0;
    rst_b = 1'b1; re_b = 1'b0; we_b = 1'b0; ra1_b = 5'd0; ra2_b = 5'd0; wa_b = 5'd0; wdat_b = 8'd0;

    // 1: reset, 16 init cycles, read enable has no effect, write during init dropped
    tick(); tick();
    rst = 1'b0; re = 1'b1; ra1 = 4'd3; ra2 = 4'd4;
    for (int i = 0; i < 16; i++) begin
      check("init_ready", {31'd0, rdy}, 32'd0);
      check("init_rd1", rd1, 32'd0);
      check("init_rd2", rd2, 32'd0);
      check("init_wdrop", {31'd0, wdrop}, (i == 3) ? 32'd1 : 32'd0);
      if (i == 2) begin
        we = 1'b1; wa = 4'd7; wdat = 32'h77;
      end else begin
        we = 1'b0;
      end
      tick();
    end
    check("ready_17th", {31'd0, rdy}, 32'd1);
    check("wdrop_after", {31'd0, wdrop}, 32'd0);

    // 2: init contents, R7 must still be 7 (dropped write)
    for (int k = 0; k < 16; k++) begin
      ra1 = 4'(k); ra2 = 4'(15 - k); re = 1'b1;
      tick();
      check("init_r1", rd1, 32'(k));
      check("init_r2", rd2, 32'(15 - k));
    end

    // 3: write then read, hold while rewritten
    re = 1'b0; we = 1'b1; wa = 4'd5; wdat = 32'hDEADBEEF;
    tick();
    we = 1'b0; re = 1'b1; ra1 = 4'd5;
    tick();
    check("wr_rd5", rd1, 32'hDEADBEEF);
    re = 1'b0; we = 1'b1; wa = 4'd5; wdat = 32'h1;
    tick();
    check("hold_rd5", rd1, 32'hDEADBEEF);
    we = 1'b0; re = 1'b1;
    tick();
    check("reread5", rd1, 32'h1);

    // boundary addresses 0 and 15
    we = 1'b1; wa = 4'd15; wdat = 32'h0F0F0F0F; re = 1'b0;
    tick();
    wa = 4'd0; wdat = 32'h12345678;
    tick();
    we = 1'b0; re = 1'b1; ra1 = 4'd0; ra2 = 4'd15;
    tick();
    check("r0", rd1, 32'h12345678);
    check("r15", rd2, 32'h0F0F0F0F);

    // 4: collision with write-first bypass, both ports
    we = 1'b1; wa = 4'd3; wdat = 32'hA5A5A5A5; ra1 = 4'd3; ra2 = 4'd3; re = 1'b1;
    tick();
    check("byp_p1", rd1, 32'hA5A5A5A5);
    check("byp_p2", rd2, 32'hA5A5A5A5);
    we = 1'b0;
    tick();
    check("after_p1", rd1, 32'hA5A5A5A5);
    check("after_p2", rd2, 32'hA5A5A5A5);
    // bypass decided per port
    we = 1'b1; wa = 4'd9; wdat = 32'h99; ra1 = 4'd9; ra2 = 4'd10;
    tick();
    check("byp_only1", rd1, 32'h99);
    check("nobyp2", rd2, 32'd10);
    we = 1'b0;

    // 6: reset mid-operation
    we = 1'b1; wa = 4'd0; wdat = 32'hFFFF; re = 1'b0;
    tick();
    we = 1'b0; rst = 1'b1;
    tick();
    check("mid_rst_ready", {31'd0, rdy}, 32'd0);
    check("mid_rst_rd1", rd1, 32'd0);
    check("mid_rst_rd2", rd2, 32'd0);
    rst = 1'b0; re = 1'b1; ra1 = 4'd0; ra2 = 4'd15;
    for (int i = 0; i < 15; i++) tick();
    check("reinit_busy", {31'd0, rdy}, 32'd0);
    check("reinit_rd1", rd1, 32'd0);
    tick();
    check("reinit_ready", {31'd0, rdy}, 32'd1);
    tick();
    check("reinit_r0", rd1, 32'd0);
    check("reinit_r15", rd2, 32'd15);

    // sweep: 32 x 8, init takes 32 cycles, R31 = 8'h1F, read-first collision
    tick();
    rst_b = 1'b0;
    cnt = 0;
    while (!rdy_b && cnt < 100) begin
      tick();
      cnt++;
    end
    check("b_init_cycles", 32'(cnt), 32'd32);
    re_b = 1'b1; ra1_b = 5'd31; ra2_b = 5'd17;
    tick();
    check("b_r31", {24'd0, rd1_b}, 32'h1F);
    check("b_r17", {24'd0, rd2_b}, 32'h11);
    we_b = 1'b1; wa_b = 5'd4; wdat_b = 8'hC3; ra1_b = 5'd4; ra2_b = 5'd4;
    tick();
    check("b_rdfirst1", {24'd0, rd1_b}, 32'd4);
    check("b_rdfirst2", {24'd0, rd2_b}, 32'd4);
    we_b = 1'b0;
    tick();
    check("b_new1", {24'd0, rd1_b}, 32'hC3);
    check("b_new2", {24'd0, rd2_b}, 32'hC3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_reg_file_sync
